// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Exception beats jump, jump beats branch.
  function automatic logic [31:0] redir_select(
    input logic        exc,
    input logic [31:0] exc_vec,
    input logic        jump,
    input logic [31:0] jump_tgt,
    input logic [31:0] br_tgt
  );
    logic [31:0] tgt;
    if (exc) begin
      tgt = exc_vec;
    end else if (jump) begin
      tgt = jump_tgt;
    end else begin
      tgt = br_tgt;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/fetch_redirect.sv
// Redirect priority mux plus the register that remembers a redirect
// which arrived while a fetch was still waiting for its ack.
module fetch_redirect
  import fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        exc_i,
  input  logic [31:0] exc_vec_i,
  input  logic        jump_i,
  input  logic [31:0] jump_tgt_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_tgt_i,
  input  logic        load_i,
  input  logic        clr_i,
  output logic        redir_o,
  output logic [31:0] redir_tgt_o,
  output logic        pend_v_o,
  output logic [31:0] pend_tgt_o
);

  logic        pend_v_r;
  logic [31:0] pend_tgt_r;

  assign redir_o     = exc_i | jump_i | br_taken_i;
  assign redir_tgt_o = redir_select(exc_i, exc_vec_i, jump_i, jump_tgt_i, br_tgt_i);
  assign pend_v_o    = pend_v_r;
  assign pend_tgt_o  = pend_tgt_r;

  // Pending redirect: newest one wins, dropped once the stale fetch returns.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_v_r   <= 1'b0;
      pend_tgt_r <= 32'h0000_0000;
    end else if (clr_i) begin
      pend_v_r   <= 1'b0;
      pend_tgt_r <= pend_tgt_r;
    end else if (load_i && redir_o) begin
      pend_v_r   <= 1'b1;
      pend_tgt_r <= redir_tgt_o;
    end else begin
      pend_v_r   <= pend_v_r;
      pend_tgt_r <= pend_tgt_r;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives next-PC, runs the imem req/ack handshake,
// resolves redirects and holds an instruction while decode stalls.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc4_i,
  input  logic        stall_i,
  input  logic        exc_i,
  input  logic [31:0] exc_vec_i,
  input  logic        jump_i,
  input  logic [31:0] jump_tgt_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_tgt_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [31:0] npc_o,
  output logic        fetch_err_o
);

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_e     state_r;
  fetch_state_e     state_nxt_s;
  logic [31:0]      ibuf_r;
  logic [CNT_W-1:0] cnt_r;
  logic             err_r;

  logic             redir_s;
  logic [31:0]      redir_tgt_s;
  logic             pend_v_s;
  logic [31:0]      pend_tgt_s;
  logic             pend_load_s;
  logic             pend_clr_s;
  logic             ibuf_load_s;

  fetch_redirect u_redirect (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .exc_i       (exc_i),
    .exc_vec_i   (exc_vec_i),
    .jump_i      (jump_i),
    .jump_tgt_i  (jump_tgt_i),
    .br_taken_i  (br_taken_i),
    .br_tgt_i    (br_tgt_i),
    .load_i      (pend_load_s),
    .clr_i       (pend_clr_s),
    .redir_o     (redir_s),
    .redir_tgt_o (redir_tgt_s),
    .pend_v_o    (pend_v_s),
    .pend_tgt_o  (pend_tgt_s)
  );

  // The address is simply the PC; npc_o = pc_i keeps it stable until ack.
  assign imem_addr_o = pc_i;
  assign fetch_err_o = err_r;

  // Per-state outputs, next PC and next state.
  always_comb begin
    state_nxt_s  = state_r;
    imem_req_o   = 1'b0;
    inst_o       = 32'h0000_0000;
    inst_valid_o = 1'b0;
    npc_o        = RESET_VEC;
    pend_load_s  = 1'b0;
    pend_clr_s   = 1'b0;
    ibuf_load_s  = 1'b0;
    case (state_r)
      BOOT: begin
        npc_o       = RESET_VEC;
        state_nxt_s = FETCH;
      end
      FETCH: begin
        imem_req_o = 1'b1;
        inst_o     = imem_rdata_i;
        if (!imem_ack_i) begin
          npc_o       = pc_i;
          pend_load_s = 1'b1;
        end else if (redir_s || pend_v_s) begin
          // Returning instruction is stale: drop it, current redirect first.
          npc_o      = redir_s ? redir_tgt_s : pend_tgt_s;
          pend_clr_s = 1'b1;
        end else if (!stall_i) begin
          inst_valid_o = 1'b1;
          npc_o        = pc4_i;
        end else begin
          inst_valid_o = 1'b1;
          npc_o        = pc_i;
          ibuf_load_s  = 1'b1;
          state_nxt_s  = HOLD;
        end
      end
      HOLD: begin
        inst_o       = ibuf_r;
        inst_valid_o = 1'b1;
        if (redir_s) begin
          inst_valid_o = 1'b0;
          npc_o        = redir_tgt_s;
          state_nxt_s  = FETCH;
        end else if (!stall_i) begin
          npc_o       = pc4_i;
          state_nxt_s = FETCH;
        end else begin
          npc_o = pc_i;
        end
      end
      default: begin
        state_nxt_s = BOOT;
      end
    endcase
  end

  // State, held instruction, ack-wait counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= BOOT;
      ibuf_r  <= 32'h0000_0000;
      cnt_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (ibuf_load_s) begin
        ibuf_r <= imem_rdata_i;
      end else begin
        ibuf_r <= ibuf_r;
      end
      if ((state_r == FETCH) && !imem_ack_i) begin
        if (cnt_r == CNT_LAST) begin
          cnt_r <= cnt_r;
          err_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
          err_r <= err_r;
        end
      end else begin
        cnt_r <= '0;
        err_r <= err_r;
      end
    end
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the pipeline front end. It drives the program counter's next-value input (`npc_o`) every cycle and runs the request/acknowledge handshake with instruction memory. It resolves redirects from exception, jump and branch, including redirects that arrive while a fetch is outstanding. It holds a fetched instruction while decode is stalled. Sits between the PC register, instruction memory and the IF/ID boundary.

## Interface
Parameters:
- `RESET_VEC`, 32'h0000_0000, first fetch address; must equal the PC reset value.
- `TIMEOUT`, 16, cycles in FETCH without ack before `fetch_err_o` sets (≥2).

Ports:
- `clk_i` in 1: clock; single clock domain.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `pc_i` in 32: current PC register value.
- `pc4_i` in 32: `pc_i + 4` from the PC block.
- `stall_i` in 1: decode cannot accept an instruction this cycle.
- `exc_i` in 1, `exc_vec_i` in 32: exception redirect and target.
- `jump_i` in 1, `jump_tgt_i` in 32: jump redirect and target.
- `br_taken_i` in 1, `br_tgt_i` in 32: taken-branch redirect and target.
- `imem_req_o` out 1, `imem_addr_o` out 32: fetch request; address is `pc_i`.
- `imem_ack_i` in 1, `imem_rdata_i` in 32: instruction valid this cycle, and its data.
- `inst_o` out 32, `inst_valid_o` out 1: instruction offered to decode; accepted when `inst_valid_o & ~stall_i`.
- `npc_o` out 32: next PC; the PC register loads it unconditionally every edge.
- `fetch_err_o` out 1: sticky fetch-timeout flag.

## Operation
- Redirect priority: exc > jump > branch. `redir` = OR of the three; `redir_tgt` is the selected target.
- The pending-redirect register (`pend_v`, `pend_tgt`) holds a redirect taken while a fetch is outstanding. A newer redirect overwrites it.
- BOOT (entered on reset):
  - `imem_req_o` = 0, `npc_o` = `RESET_VEC`.
  - Goes to FETCH on the next edge.
- FETCH:
  - `imem_req_o` = 1, `imem_addr_o` = `pc_i`. The address stays stable until ack.
  - No ack: `npc_o` = `pc_i`. A `redir` this cycle loads the pending register.
  - Ack with `redir` or `pend_v`:
    - The instruction is discarded; `inst_valid_o` = 0.
    - `npc_o` = `redir` ? `redir_tgt` : `pend_tgt`. The current-cycle redirect wins.
    - `pend_v` clears; stay in FETCH.
  - Ack, no redirect, `~stall_i`:
    - `inst_o` = `imem_rdata_i` (combinational pass-through), `inst_valid_o` = 1.
    - `npc_o` = `pc4_i`; stay in FETCH.
  - Ack, no redirect, `stall_i`:
    - `inst_valid_o` = 1, and `imem_rdata_i` is captured into `ibuf`.
    - `npc_o` = `pc_i`; go to HOLD.
- HOLD:
  - `imem_req_o` = 0, `inst_o` = `ibuf`, `inst_valid_o` = 1.
  - `redir`: `inst_valid_o` = 0, `npc_o` = `redir_tgt`, go to FETCH.
  - Otherwise, `~stall_i`: `npc_o` = `pc4_i`, go to FETCH.
  - Otherwise: `npc_o` = `pc_i`, stay in HOLD.
- Timeout counter:
  - Counts consecutive FETCH cycles without ack.
  - Clears on ack or when leaving FETCH.
  - At `TIMEOUT-1` it sets `fetch_err_o`. The flag is cleared only by reset; the FSM keeps waiting.
- Targets are used as given; alignment checks belong to the exception unit.

## Timing
- Reset (asynchronous assert, at any time including mid-fetch):
  - State goes to BOOT; `pend_v`, `ibuf` and the counter clear.
  - `imem_req_o`, `inst_valid_o` and `fetch_err_o` are 0; `inst_o` is 0; `npc_o` = `RESET_VEC`.
  - Any outstanding memory ack after reset is ignored.
- First request is asserted in the cycle after reset release plus one edge (BOOT lasts exactly one cycle).
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle, zero-bubble sequential fetch.
- Redirect penalty:
  - The target is fetched in the cycle after the redirect cycle, or in the cycle after the ack when the redirect was pending.
- Stall and redirect in the same cycle: the redirect wins and the instruction is dropped.

## Structure
- Shared package `fetch_pkg`: state enum `fetch_state_e {BOOT, FETCH, HOLD}`, and `INST_NOP` = 32'h0000_0013 for verification.
- One sub-module, `fetch_redirect`: the priority mux plus the pending-redirect register. Its outputs are `redir`, `redir_tgt`, `pend_v` and `pend_tgt`, with a clear input driven by the FSM.

## Test plan
- Reset release, with memory acking every cycle and returning `addr^32'hA5A5_0000`:
  - BOOT lasts one cycle with `npc_o` = 0.
  - Addresses then go 0, 4, 8, C, each with `inst_valid_o` = 1.
- Memory acks 3 cycles after req:
  - `imem_addr_o` holds 0x10 for 3 cycles while `npc_o` = 0x10.
  - On ack, `npc_o` = 0x14.
- Branch to 0x200 two cycles before a delayed ack at address 0x40:
  - The 0x40 instruction is dropped (`inst_valid_o` = 0).
  - The next `imem_addr_o` is 0x200.
- `stall_i` held for 4 cycles on the instruction at 0x20:
  - `inst_o` stays constant for 5 cycles while the PC holds 0x20.
  - The next fetch is 0x24.
- Exception to 0x80 and jump to 0x300 in the same cycle, during HOLD: the next fetch is 0x80.
- No ack for 16 cycles: `fetch_err_o` rises and stays set until `rst_n_i` is asserted low mid-wait, which clears all outputs.
